// File: rtl/majority_rr_sched.sv
// Round-robin scheduler feeding a shared popcount/majority evaluator.
// Two-stage pipe (capture S1, output S2) with saturating delivery statistics.
module majority_rr_sched #(
  parameter  int NREQ   = 4,
  parameter  int DW     = 8,
  parameter  int THRESH = 4,
  parameter  int CW     = 16,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CNTW   = $clog2(DW) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [DW-1:0]        rsp_data,
  output logic [CNTW-1:0]      rsp_count,
  output logic                 rsp_detect,
  output logic [CW-1:0]        stat_total,
  output logic [CW-1:0]        stat_detect
);

  function automatic logic [CNTW-1:0] popcnt(input logic [DW-1:0] d);
    logic [CNTW-1:0] c;
    c = '0;
    for (int i = 0; i < DW; i++) c = c + CNTW'(d[i]);
    return c;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CW'(1) : v;
  endfunction

  logic [IDW-1:0]  r_ptr;
  logic            r_s1_vld;
  logic [DW-1:0]   r_s1_data;
  logic [IDW-1:0]  r_s1_id;
  logic            r_rsp_vld;
  logic [IDW-1:0]  r_rsp_id;
  logic [DW-1:0]   r_rsp_data;
  logic [CNTW-1:0] r_rsp_cnt;
  logic            r_rsp_det;
  logic [CW-1:0]   r_stat_total;
  logic [CW-1:0]   r_stat_detect;

  logic            w_out_adv;
  logic            w_s1_adv;
  logic            w_gnt_any;
  logic [IDW-1:0]  w_gnt_id;
  logic [DW-1:0]   w_gnt_data;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [IDW:0]    w_sum;
  logic [IDW-1:0]  w_scan;
  logic [CNTW-1:0] w_s1_cnt;
  logic            w_s1_det;

  assign w_out_adv = !r_rsp_vld || rsp_ready;
  assign w_s1_adv  = !r_s1_vld || w_out_adv;

  // Scan from the pointer upward with wrap; first valid requester wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_sum     = '0;
    w_scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum  = {1'b0, r_ptr} + (IDW+1)'(k);
      w_scan = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ)) : w_sum[IDW-1:0];
      if (!w_gnt_any && req_valid[w_scan]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_scan;
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gnt_id == IDW'(i)) w_gnt_data = req_data[i*DW +: DW];
  end

  always_comb begin
    req_ready = '0;
    if (!rst && w_s1_adv && w_gnt_any) req_ready[w_gnt_id] = 1'b1;
  end

  assign w_ptr_nxt = (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + IDW'(1);
  assign w_s1_cnt  = popcnt(r_s1_data);
  assign w_s1_det  = (w_s1_cnt >= CNTW'(THRESH));

  // Stage 1: capture the granted byte
  always_ff @(posedge clk) begin
    if (w_s1_adv && w_gnt_any) begin
      r_s1_data <= w_gnt_data;
      r_s1_id   <= w_gnt_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr         <= '0;
      r_s1_vld      <= 1'b0;
      r_rsp_vld     <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_data    <= '0;
      r_rsp_cnt     <= '0;
      r_rsp_det     <= 1'b0;
      r_stat_total  <= '0;
      r_stat_detect <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_vld <= w_gnt_any;
        if (w_gnt_any) r_ptr <= w_ptr_nxt;
      end
      // Stage 2: evaluate and hold the result until consumed
      if (w_out_adv) begin
        r_rsp_vld  <= r_s1_vld;
        r_rsp_id   <= r_s1_id;
        r_rsp_data <= r_s1_data;
        r_rsp_cnt  <= w_s1_cnt;
        r_rsp_det  <= w_s1_det;
      end
      if (r_rsp_vld && rsp_ready) begin
        r_stat_total  <= sat_inc(r_stat_total, 1'b1);
        r_stat_detect <= sat_inc(r_stat_detect, r_rsp_det);
      end
    end
  end

  assign rsp_valid   = r_rsp_vld;
  assign rsp_id      = r_rsp_id;
  assign rsp_data    = r_rsp_data;
  assign rsp_count   = r_rsp_cnt;
  assign rsp_detect  = r_rsp_det;
  assign stat_total  = r_stat_total;
  assign stat_detect = r_stat_detect;

endmodule

// File: tb/tb_majority_rr_sched.sv
// Scoreboard bench for majority_rr_sched: directed vectors, queued expectations,
// and a monitor that checks each delivered result.
module tb_majority_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic [3:0]  rsp_count;
  logic        rsp_detect;
  logic [15:0] stat_total;
  logic [15:0] stat_detect;

  logic [3:0]  b_req_ready;
  logic        b_rsp_valid;
  logic [1:0]  b_rsp_id;
  logic [7:0]  b_rsp_data;
  logic [3:0]  b_rsp_count;
  logic        b_rsp_detect;
  logic [3:0]  b_stat_total;
  logic [3:0]  b_stat_detect;

  majority_rr_sched #(.NREQ(4), .DW(8), .THRESH(4), .CW(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_count(rsp_count),
    .rsp_detect(rsp_detect), .stat_total(stat_total), .stat_detect(stat_detect)
  );

  majority_rr_sched #(.NREQ(4), .DW(8), .THRESH(4), .CW(4)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .rsp_count(b_rsp_count),
    .rsp_detect(b_rsp_detect), .stat_total(b_stat_total), .stat_detect(b_stat_detect)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic [3:0] cnt;
    logic       det;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[4][$];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_count", rsp_count, e.cnt);
        chk("rsp_detect", rsp_detect, e.det);
      end
    end
  end

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (tx_q[i].size() != 0);
      req_data[i*8 +: 8] = (tx_q[i].size() != 0) ? tx_q[i][0] : 8'h00;
    end
  endtask

  task automatic issue(input int id, input logic [7:0] d, input int c);
    exp_t e;
    tx_q[id].push_back(d);
    e.id = 2'(id); e.data = d; e.cnt = 4'(c); e.det = (c >= 4);
    exp_q.push_back(e);
  endtask

  task automatic step(output logic [3:0] xf);
    @(negedge clk);
    xf = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (xf[i]) void'(tx_q[i].pop_front());
    refresh();
  endtask

  function automatic bit any_tx();
    return (tx_q[0].size() + tx_q[1].size() + tx_q[2].size() + tx_q[3].size()) != 0;
  endfunction

  task automatic drain(input int lim, output int n);
    logic [3:0] x;
    n = 0;
    while ((exp_q.size() != 0 || any_tx()) && n < lim) begin
      step(x);
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [3:0] xf;
  int         n;
  int         absorbed;

  initial begin
    rst = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF; req_data = '0;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_count", rsp_count, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_stat_total", stat_total, 0);
    chk("rst_stat_detect", stat_detect, 0);
    refresh();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // single requester, latency and threshold edge
    issue(0, 8'h0F, 4);
    refresh();
    step(xf);
    chk("t1_grant", xf, 1);
    chk("t1_lat_s1", rsp_valid, 0);
    step(xf);
    chk("t1_lat_s2", rsp_valid, 1);
    issue(0, 8'h07, 3);
    refresh();
    drain(20, n);

    // round-robin, all requesters continuously valid
    do_reset();
    chk("t2_stat_clr", stat_total, 0);
    issue(0, 8'h01, 1); issue(1, 8'h03, 2); issue(2, 8'h07, 3); issue(3, 8'h1F, 5);
    issue(0, 8'hFF, 8); issue(1, 8'hF0, 4); issue(2, 8'h0E, 3); issue(3, 8'h00, 0);
    refresh();
    drain(40, n);
    chk("t2_cycles", n, 10);

    // backpressure with full pipe
    rsp_ready = 1'b0;
    issue(0, 8'hAA, 4); issue(1, 8'h55, 4); issue(2, 8'hC0, 2); issue(3, 8'hE7, 6);
    issue(0, 8'h80, 1); issue(1, 8'h11, 2); issue(2, 8'h7F, 7); issue(3, 8'h18, 2);
    issue(0, 8'hFE, 7); issue(1, 8'h3C, 4); issue(2, 8'h08, 1); issue(3, 8'h99, 4);
    refresh();
    absorbed = 0;
    for (int s = 1; s <= 5; s++) begin
      step(xf);
      absorbed += $countones(xf);
      if (s >= 2) begin
        chk("t3_hold_valid", rsp_valid, 1);
        chk("t3_hold_id", rsp_id, 0);
        chk("t3_hold_data", rsp_data, 8'hAA);
        chk("t3_hold_count", rsp_count, 4);
        chk("t3_stall_ready", req_ready, 0);
      end
    end
    chk("t3_absorbed", absorbed, 2);
    rsp_ready = 1'b1;
    drain(60, n);
    chk("t3_stat_total", stat_total, 20);
    chk("t3_stat_detect", stat_detect, 10);
    chk("sat_stat_total", b_stat_total, 15);
    chk("sat_stat_detect", b_stat_detect, 10);

    // exhaustive byte sweep on requester 2
    do_reset();
    for (int v = 0; v < 256; v++) issue(2, 8'(v), $countones(8'(v)));
    refresh();
    drain(400, n);
    chk("sweep_cycles", n, 258);
    chk("sweep_stat_total", stat_total, 256);
    chk("sweep_stat_detect", stat_detect, 163);
    chk("sweep_sat_detect", b_stat_detect, 15);

    // reset while both stages are full
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_q[i].push_back(8'hF3);
      tx_q[i].push_back(8'h3F);
    end
    refresh();
    step(xf); step(xf); step(xf);
    chk("t5_full_before", rsp_valid, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", rsp_valid, 0);
    chk("t5_rst_total", stat_total, 0);
    chk("t5_rst_detect", stat_detect, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_count", rsp_count, 0);
    for (int i = 0; i < 4; i++) tx_q[i].delete();
    issue(1, 8'h3F, 6);
    issue(3, 8'h01, 1);
    refresh();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drain(20, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/majority_rr_sched.md
Name: majority_rr_sched

Overview:
- Round-robin scheduler that shares one 8-bit majority evaluator among NREQ requesters.
- Each requester offers a byte over valid/ready. The block grants one requester per cycle, pipelines the byte through a capture stage and an evaluate stage, and returns the set-bit count and detect flag tagged with the requester ID.
- Detect means popcount >= THRESH (majority = 4 of 8).
- Sits between multiple producer blocks and the shared majority datapath. Also keeps saturating statistics counters.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width per requester.
- THRESH, 4, detect asserted when popcount >= THRESH.
- CW, 16, statistics counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*DW  requester i at bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  clog2(NREQ)  requester index of result.
- rsp_data  out  DW  echoed input byte.
- rsp_count  out  clog2(DW)+1  number of ones.
- rsp_detect  out  1  rsp_count >= THRESH.
- stat_total  out  CW  results delivered, saturating.
- stat_detect  out  CW  delivered results with detect=1, saturating.

Behaviour:
- Reset (async, rst=1) values:
  - rsp_valid=0; rsp_id, rsp_data, rsp_count, rsp_detect = 0.
  - stat_total = stat_detect = 0.
  - Capture stage empty; round-robin pointer = 0.
  - req_ready = 0 while rst is high.
- Pipeline:
  - S1 is the capture register: valid bit, data, id.
  - S2 is the output register: drives the rsp_* ports.
  - Latency: a byte transferred at edge k appears on rsp_* after edge k+1 (rsp_valid high in the cycle after the capture cycle) when there is no backpressure.
  - Throughput: one result per cycle.
- Stall rules:
  - out_adv = !rsp_valid || rsp_ready.
  - s1_adv = !s1_valid || out_adv.
  - Grant is issued only when s1_adv=1. Otherwise req_ready = 0.
  - S2 loads S1 when out_adv. It loads rsp_valid <= s1_valid; the count and detect are computed combinationally from S1 data at load.
  - S2 holds all rsp_* outputs stable while rsp_valid && !rsp_ready.
- Arbitration:
  - Round-robin starting from pointer p. The grant goes to the first i in p, p+1, …, NREQ-1, 0, … with req_valid[i].
  - req_ready is at most one-hot, combinational from req_valid, p and s1_adv.
  - Requesters must not make req_valid depend on req_ready.
  - After a transfer to i, p <= (i+1) mod NREQ. With no transfer, p is unchanged.
  - No requester waits more than NREQ-1 grants while continuously valid.
- Arithmetic:
  - rsp_count is a full popcount (0..DW).
  - rsp_detect = (rsp_count >= THRESH); count=3 gives 0, count=4 gives 1.
- Statistics:
  - Updated on each rsp_valid && rsp_ready handshake.
  - stat_total += 1; stat_detect += rsp_detect.
  - Both saturate at all-ones and never wrap.
- Boundary cases:
  - Full pipe (S1 and S2 valid, rsp_ready=0): req_ready = 0 and nothing is lost.
  - Full pipe with rsp_ready rising: in the same cycle S2 takes S1, S1 takes the new grant, and req_ready may be asserted.
  - No req_valid: S1 drains and p holds.
  - rst asserted mid-operation: in-flight data is discarded, outputs clear immediately, and counters clear.
  - First grant after reset release goes to the lowest valid index starting from 0.

Test Plan:
- Single requester 0, data=8'h0F, rsp_ready=1 → one cycle later rsp_valid=1, rsp_id=0, rsp_count=4, rsp_detect=1. Then 8'h07 → count=3, detect=0.
- All 4 requesters valid continuously with distinct data → grant order 0,1,2,3,0,… and rsp_id sequence matches. One result per cycle.
- rsp_ready=0 for 5 cycles with all requesters valid → exactly 2 bytes absorbed (S2, S1), then req_ready=0. rsp_* stable throughout. On release, results arrive in grant order with no loss or duplicates.
- Exhaustive sweep: requester 2 sends every value 0..255 → each rsp_count equals popcount. rsp_detect matches count >= 4. stat_total=256, stat_detect=163.
- Assert rst for 1 cycle while S1 and S2 are full → rsp_valid=0 immediately, stats=0. Afterwards the first grant goes to the lowest valid index.
- Force stat_total near saturation (CW=4 build, 20 results) → stat_total stays 15 and does not wrap.
